console_rx_arbiter: RTL and testbench

Merges the byte streams of NUM_SRC uart_rx receivers onto one 8-bit valid/ready output stream for the console multiplexer. Each source has a one-byte holding slot, and a round-robin scheduler drains the slots. Whenever the emitting source changes, a tag byte identifying the new source goes out before its data byte. Per-source sticky overrun flags report bytes lost because a slot was still full.

---
 rtl/console_rx_arbiter_pkg.sv | 7 +
 rtl/console_rx_arbiter_if.sv | 9 +
 rtl/console_rx_arbiter_slot.sv | 35 +++
 rtl/console_rx_arbiter.sv | 91 +++++++++
 tb/tb_console_rx_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/console_rx_arbiter_pkg.sv
// console_mux_pkg: shared state type, tag default and source-id width for the console rx arbiter
package console_mux_pkg;
  localparam int MAX_SRC = 16;
  localparam int SRC_W = $clog2(MAX_SRC);
  localparam logic [7:0] TAG_BASE_DEF = 8'hF0;
  typedef enum logic [1:0] {IDLE, SEND_TAG, SEND_DATA} state_t;
endpackage

// File: rtl/console_rx_arbiter_if.sv
// console_rx_arbiter_if: valid/ready byte stream toward the console multiplexer
interface console_rx_arbiter_if #(parameter int DATA_W = 8) ();
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_is_tag;
  logic              out_ready;
  modport master (output out_valid, out_data, out_is_tag, input out_ready);
  modport slave  (input out_valid, out_data, out_is_tag, output out_ready);
endinterface

// File: rtl/console_rx_arbiter_slot.sv
// console_rx_slot: one-byte holding slot with rising-edge capture and sticky overrun
module console_rx_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              drain,
  input  logic              clr,
  output logic              full,
  output logic [DATA_W-1:0] data,
  output logic              overrun
);
  logic prev, cap_q, cap, store, lost;
  assign cap   = rx_ready & ~prev;
  assign store = cap & (~full | drain);
  assign lost  = cap & full & ~drain;
  // full lags the data write by one cycle, so a refill during drain reappears a cycle later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev    <= 1'b1;
      cap_q   <= 1'b0;
      full    <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else begin
      prev    <= rx_ready;
      cap_q   <= store;
      data    <= store ? rx_data : data;
      full    <= cap_q | (full & ~drain);
      overrun <= lost | (overrun & ~clr);
    end
  end
endmodule

// File: rtl/console_rx_arbiter.sv
// console_rx_arbiter: round-robin merge of uart_rx bytes into one tagged valid/ready stream
module console_rx_arbiter
  import console_mux_pkg::*;
#(
  parameter int         NUM_SRC  = 4,
  parameter int         DATA_W   = 8,
  parameter logic [7:0] TAG_BASE = TAG_BASE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        rx_ready,
  input  logic [NUM_SRC*DATA_W-1:0] rx_data,
  console_rx_arbiter_if.master      bus,
  output logic [NUM_SRC-1:0]        overrun,
  input  logic [NUM_SRC-1:0]        overrun_clr
);
  localparam logic [SRC_W:0] NS   = (SRC_W+1)'(NUM_SRC);
  localparam logic [SRC_W:0] NONE = {1'b1, {SRC_W{1'b0}}};
  state_t            state, state_nxt;
  logic [SRC_W-1:0]  g, pick, rr_ptr;
  logic [SRC_W:0]    last_src, idx;
  logic              any_full, hs;
  logic [MAX_SRC-1:0] full;
  logic [NUM_SRC-1:0] drain;
  logic [DATA_W-1:0] slot_data [MAX_SRC];

  assign hs = bus.out_valid & bus.out_ready;

  for (genvar i = 0; i < MAX_SRC; i++) begin : g_slot
    if (i < NUM_SRC) begin : g_on
      assign drain[i] = state == SEND_DATA && hs && g == SRC_W'(i);
      console_rx_slot #(.DATA_W(DATA_W)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_ready(rx_ready[i]),
        .rx_data (rx_data[i*DATA_W +: DATA_W]),
        .drain   (drain[i]),
        .clr     (overrun_clr[i]),
        .full    (full[i]),
        .data    (slot_data[i]),
        .overrun (overrun[i])
      );
    end else begin : g_off
      assign full[i]      = 1'b0;
      assign slot_data[i] = '0;
    end
  end

  // scan downward so the nearest full slot at or after rr_ptr is the last one written
  always_comb begin
    any_full = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      idx = idx >= NS ? idx - NS : idx;
      if (full[idx[SRC_W-1:0]]) begin
        any_full = 1'b1;
        pick     = idx[SRC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      g        <= '0;
      last_src <= NONE;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      g        <= (state == IDLE && any_full) ? pick : g;
      last_src <= (state == SEND_TAG && bus.out_ready) ? {1'b0, g} : last_src;
      rr_ptr   <= (state == SEND_DATA && bus.out_ready) ? (({1'b0, g} == NS - 1'b1) ? '0 : g + 1'b1) : rr_ptr;
    end
  end

  always_comb begin
    state_nxt = state == IDLE     ? (any_full ? (({1'b0, pick} != last_src) ? SEND_TAG : SEND_DATA) : IDLE) :
                state == SEND_TAG ? (bus.out_ready ? SEND_DATA : SEND_TAG) :
                                    (bus.out_ready ? IDLE : SEND_DATA);
  end

  // the granted slot is frozen while granted, so outputs decode straight from state and g
  always_comb begin
    bus.out_valid  = state != IDLE;
    bus.out_is_tag = state == SEND_TAG;
    bus.out_data   = state == SEND_TAG  ? (DATA_W'(TAG_BASE) | DATA_W'(g)) :
                     state == SEND_DATA ? slot_data[g] : '0;
  end
endmodule

// File: tb/tb_console_rx_arbiter.sv
// tb_console_rx_arbiter: scoreboard bench with a rotation-order reference model
module tb_console_rx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] rx_ready = '0;
  logic [N-1:0] overrun_clr = '0;
  logic [N-1:0] overrun;
  logic [N*8-1:0] rx_data = '0;
  logic rand_ready = 1'b0;
  logic ready_force = 1'b0;
  logic rnd = 1'b1;
  int checks = 0;
  int errs = 0;
  int m_rr = 0;
  int m_last = -1;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic st_prev = 1'b0;
  logic [9:0] st_val = '0;

  console_rx_arbiter_if #(.DATA_W(8)) bus ();
  assign bus.out_ready = rand_ready ? rnd : ready_force;

  console_rx_arbiter #(.NUM_SRC(N), .DATA_W(8), .TAG_BASE(8'hF0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .bus        (bus),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    rnd = $urandom_range(0, 3) != 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected output: full slots drained in rotation from the pointer, tag only on source change
  task automatic model_burst(input logic [N-1:0] mask, input logic [N*8-1:0] d);
    int base, s;
    base = m_rr;
    for (int k = 0; k < N; k++) begin
      s = (base + k) % N;
      if (mask[s]) begin
        if (s != m_last) exp_q.push_back({1'b1, 8'hF0 | 8'(s)});
        exp_q.push_back({1'b0, d[s*8 +: 8]});
        m_last = s;
        m_rr = (s + 1) % N;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got %0h tag %0b, expected no output", bus.out_data, bus.out_is_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_byte", {bus.out_is_tag, bus.out_data}, mon_e);
      end
    end
    if (st_prev) check("stall_stable", {bus.out_valid, bus.out_is_tag, bus.out_data}, st_val);
    st_prev = rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b0;
    st_val = {1'b1, bus.out_is_tag, bus.out_data};
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] mask, input logic [N*8-1:0] d, input logic push);
    rx_data = d;
    rx_ready = mask;
    if (push) model_burst(mask, d);
    step(2);
    rx_ready = '0;
    step(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && n < 500) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errs++;
      $display("FAIL wait_idle: got %0d bytes still pending expected 0", exp_q.size());
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      step(1);
      n++;
    end
    check("wait_valid", bus.out_valid, 1);
  endtask

  initial begin
    logic [N-1:0] mask;
    rx_ready = 4'b0001;
    rx_data = 32'h99;
    step(3);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_tag", bus.out_is_tag, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("no_capture_valid", bus.out_valid, 0);
    end
    rx_ready = '0;
    step(2);

    ready_force = 1'b1;
    rx_data = 32'h0041_0000;
    rx_ready = 4'b0100;
    model_burst(4'b0100, rx_data);
    @(posedge clk);
    @(negedge clk);
    check("latency_e1", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_e2", bus.out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency_e3", bus.out_valid, 1);
    check("first_tag", {bus.out_is_tag, bus.out_data}, 9'h1F2);
    step(1);
    rx_ready = '0;
    wait_idle();

    send(4'b0100, 32'h0042_0000, 1'b1);
    wait_idle();
    send(4'b0100, 32'h0043_0000, 1'b1);
    wait_idle();

    send(4'b0001, 32'h0000_0007, 1'b1);
    wait_idle();
    send(4'b1011, 32'h3300_2211, 1'b1);
    wait_idle();

    send(4'b0100, 32'h0077_0000, 1'b1);
    wait_idle();
    ready_force = 1'b0;
    send(4'b0001, 32'h0000_005A, 1'b1);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("stall_tag", {bus.out_valid, bus.out_is_tag, bus.out_data}, 10'h3F0);
      step(1);
    end
    ready_force = 1'b1;
    wait_idle();

    ready_force = 1'b0;
    send(4'b0010, 32'h0000_5500, 1'b1);
    send(4'b0010, 32'h0000_6600, 1'b0);
    check("overrun_set", overrun, 4'b0010);
    ready_force = 1'b1;
    wait_idle();
    check("overrun_sticky", overrun, 4'b0010);
    overrun_clr = 4'b0010;
    step(1);
    overrun_clr = '0;
    check("overrun_clr", overrun, 0);

    ready_force = 1'b0;
    send(4'b1000, 32'h1300_0000, 1'b1);
    rx_data = 32'h1400_0000;
    rx_ready = 4'b1000;
    overrun_clr = 4'b1000;
    step(1);
    overrun_clr = '0;
    step(1);
    rx_ready = '0;
    step(1);
    check("set_beats_clr", overrun, 4'b1000);
    ready_force = 1'b1;
    wait_idle();
    overrun_clr = 4'b1000;
    step(1);
    overrun_clr = '0;
    check("overrun_clr3", overrun, 0);

    ready_force = 1'b0;
    send(4'b0001, 32'h0000_00A0, 1'b1);
    wait_valid();
    ready_force = 1'b1;
    step(1);
    ready_force = 1'b0;
    check("held_data", {bus.out_valid, bus.out_is_tag, bus.out_data}, 10'h2A0);
    rx_data = 32'h0000_00A1;
    rx_ready = 4'b0001;
    ready_force = 1'b1;
    model_burst(4'b0001, rx_data);
    step(2);
    rx_ready = '0;
    wait_idle();
    check("refill_no_overrun", overrun, 0);

    rand_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      send(mask, {$urandom}, 1'b1);
      wait_idle();
    end
    rand_ready = 1'b0;
    check("random_no_overrun", overrun, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
